// File: rtl/fuel_pump_controller_if.sv
// rtl/fuel_pump_controller_if.sv - transaction, pump and cost_calculator signals of the fuel pump controller
interface fuel_pump_controller_if #(
  parameter int FUEL_W  = 8,
  parameter int PRICE_W = 8,
  parameter int COST_W  = 16
);
  logic                start;
  logic [PRICE_W-1:0]  price_in;
  logic [FUEL_W-1:0]   preset_liters;
  logic                nozzle_pulse;
  logic                stop;
  logic [FUEL_W-1:0]   fuel_amount;
  logic [PRICE_W-1:0]  price_per_liter;
  logic [COST_W-1:0]   total_cost;
  logic                pump_en;
  logic                busy;
  logic                done;
  logic [FUEL_W-1:0]   final_liters;
  logic [COST_W-1:0]   final_cost;

  // Controller side.
  modport slave (
    input  start, price_in, preset_liters, nozzle_pulse, stop, total_cost,
    output fuel_amount, price_per_liter, pump_en, busy, done,
           final_liters, final_cost
  );

  // Dispenser / cost_calculator side.
  modport master (
    output start, price_in, preset_liters, nozzle_pulse, stop, total_cost,
    input  fuel_amount, price_per_liter, pump_en, busy, done,
           final_liters, final_cost
  );
endinterface

// File: rtl/fuel_pump_controller.sv
// rtl/fuel_pump_controller.sv - sequences one pump transaction around an external cost_calculator
module fuel_pump_controller #(
  parameter int FUEL_W  = 8,
  parameter int PRICE_W = 8,
  parameter int COST_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fuel_pump_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_SETTLE   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  localparam logic [FUEL_W-1:0] COUNT_MAX = '1;

  state_t              state_q, state_d;
  logic [FUEL_W-1:0]   count_q, count_d;
  logic [PRICE_W-1:0]  price_q, price_d;
  logic [FUEL_W-1:0]   limit_q, limit_d;
  logic [FUEL_W-1:0]   final_liters_q, final_liters_d;
  logic [COST_W-1:0]   final_cost_q, final_cost_d;
  logic [FUEL_W-1:0]   count_inc;

  // Saturating liter count including this cycle's pulse; the limit check uses this value.
  assign count_inc = (bus.nozzle_pulse && (count_q != COUNT_MAX)) ? count_q + 1'b1 : count_q;

  // State and datapath registers; reset aborts any transaction and clears the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      price_q        <= '0;
      limit_q        <= '0;
      final_liters_q <= '0;
      final_cost_q   <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      price_q        <= price_d;
      limit_q        <= limit_d;
      final_liters_q <= final_liters_d;
      final_cost_q   <= final_cost_d;
    end
  end

  // Next-state logic: latch on start, count while dispensing, capture cost one cycle after stopping.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    price_d        = price_q;
    limit_d        = limit_q;
    final_liters_d = final_liters_q;
    final_cost_d   = final_cost_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          price_d = bus.price_in;
          // A zero preset means "no limit": stop only at the counter ceiling.
          limit_d = (bus.preset_liters == '0) ? COUNT_MAX : bus.preset_liters;
          count_d = '0;
          state_d = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        count_d = count_inc;
        if (bus.stop || (count_inc == limit_q)) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // count_q is frozen here, so total_cost reflects the final volume.
        final_cost_d   = bus.total_cost;
        final_liters_d = count_q;
        state_d        = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pump_en         = (state_q == S_DISPENSE);
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_DONE);
  assign bus.fuel_amount     = count_q;
  assign bus.price_per_liter = price_q;
  assign bus.final_liters    = final_liters_q;
  assign bus.final_cost      = final_cost_q;

endmodule

// File: tb/tb_fuel_pump_controller.sv
// tb/tb_fuel_pump_controller.sv - randomized and directed self-checking bench for fuel_pump_controller
module tb_fuel_pump_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fuel_pump_controller_if #(.FUEL_W(8), .PRICE_W(8), .COST_W(16)) bus ();

  fuel_pump_controller #(.FUEL_W(8), .PRICE_W(8), .COST_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // The bench plays the combinational cost_calculator.
  assign bus.total_cost = {8'd0, bus.fuel_amount} * {8'd0, bus.price_per_liter};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: active from accepted start until two edges after the
  // terminating edge; results appear one edge after termination.
  logic        m_active = 1'b0;
  logic        m_ended  = 1'b0;
  logic        m_since  = 1'b0;
  logic [7:0]  m_count  = 8'd0;
  logic [7:0]  m_price  = 8'd0;
  logic [7:0]  m_limit  = 8'd0;
  logic [7:0]  m_fl     = 8'd0;
  logic [15:0] m_fc     = 16'd0;
  logic [7:0]  m_cnt_nx;

  assign m_cnt_nx = (bus.nozzle_pulse && m_count != 8'd255) ? m_count + 8'd1 : m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_ended <= 1'b0; m_since <= 1'b0;
      m_count <= 8'd0; m_price <= 8'd0; m_limit <= 8'd0;
      m_fl <= 8'd0; m_fc <= 16'd0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1;
        m_ended  <= 1'b0;
        m_count  <= 8'd0;
        m_price  <= bus.price_in;
        m_limit  <= (bus.preset_liters == 8'd0) ? 8'd255 : bus.preset_liters;
      end
    end else if (!m_ended) begin
      m_count <= m_cnt_nx;
      if (bus.stop || m_cnt_nx == m_limit) begin
        m_ended <= 1'b1;
        m_since <= 1'b0;
      end
    end else if (!m_since) begin
      m_since <= 1'b1;
      m_fl    <= m_count;
      m_fc    <= 16'(m_count) * 16'(m_price);
    end else begin
      m_active <= 1'b0;
      m_ended  <= 1'b0;
      m_since  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("pump_en", bus.pump_en, m_active && !m_ended);
    chk("busy", bus.busy, m_active);
    chk("done", bus.done, m_active && m_ended && m_since);
    chk("fuel_amount", bus.fuel_amount, m_count);
    chk("price_per_liter", bus.price_per_liter, m_price);
    chk("final_liters", bus.final_liters, m_fl);
    chk("final_cost", bus.final_cost, m_fc);
  end

  task automatic step(input logic s, input logic p, input logic st);
    bus.start = s;
    bus.nozzle_pulse = p;
    bus.stop = st;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.nozzle_pulse = 1'b0;
    bus.stop = 1'b0;
  endtask

  task automatic begin_txn(input logic [7:0] price, input logic [7:0] preset);
    bus.price_in = price;
    bus.preset_liters = preset;
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0; bus.nozzle_pulse = 1'b0; bus.stop = 1'b0;
    bus.price_in = 8'd0; bus.preset_liters = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_final_cost", bus.final_cost, 0);
    chk("reset_fuel_amount", bus.fuel_amount, 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // 1: preset reached on the 10th pulse.
    begin_txn(8'd5, 8'd10);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    chk("t1_pump_on_9", bus.pump_en, 1);
    step(1'b0, 1'b1, 1'b0);
    chk("t1_pump_off_10", bus.pump_en, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_done", bus.done, 1);
    chk("t1_liters", bus.final_liters, 10);
    chk("t1_cost", bus.final_cost, 50);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_idle", bus.busy, 0);

    // 2: no limit, stopped after 20 pulses; done two cycles after stop.
    begin_txn(8'd3, 8'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("t2_done_early", bus.done, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_done", bus.done, 1);
    chk("t2_liters", bus.final_liters, 20);
    chk("t2_cost", bus.final_cost, 60);
    step(1'b0, 1'b0, 1'b0);

    // 3: pulse and stop together on the 15th liter.
    begin_txn(8'd4, 8'd15);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t3_liters", bus.final_liters, 15);
    chk("t3_cost", bus.final_cost, 60);
    step(1'b0, 1'b0, 1'b0);

    // 4: counter ceiling with unlimited preset.
    begin_txn(8'd255, 8'd0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_count", bus.fuel_amount, 255);
    chk("t4_liters", bus.final_liters, 255);
    chk("t4_cost", bus.final_cost, 65025);

    // 5: start while dispensing ignored; pulse during SETTLE ignored.
    begin_txn(8'd7, 8'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    bus.price_in = 8'd9;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_done", bus.done, 1);
    chk("t5_price", bus.price_per_liter, 7);
    chk("t5_liters", bus.final_liters, 8);
    chk("t5_cost", bus.final_cost, 56);
    step(1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-dispense.
    begin_txn(8'd6, 8'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pump_en", bus.pump_en, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_fuel_amount", bus.fuel_amount, 0);
    chk("t6_final_liters", bus.final_liters, 0);
    chk("t6_final_cost", bus.final_cost, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("t6_no_done", bus.done, 0);
    end
    begin_txn(8'd2, 8'd3);
    chk("t6_restart_count", bus.fuel_amount, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_liters", bus.final_liters, 3);
    chk("t6_cost", bus.final_cost, 6);
    step(1'b0, 1'b0, 1'b0);

    // Randomized transactions with stray starts, price changes and level/pulse stops.
    for (int t = 0; t < 30; t++) begin
      int n;
      logic [7:0] pre;
      pre = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
      begin_txn(8'($urandom), pre);
      n = 0;
      while (bus.busy && n < 600) begin
        bus.price_in = 8'($urandom);
        bus.preset_liters = 8'($urandom);
        step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             (n > 60) || ($urandom_range(0, 29) == 0));
        n++;
      end
      chk("rand_txn_finished", bus.busy, 0);
      repeat ($urandom_range(0, 2)) step(1'b0, $urandom_range(0, 1) == 1, 1'b0);
    end

    step(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
